// File: rtl/issue_queue.sv
// issue_queue: in-order dual-issue buffer between decode and the two execute lanes.
//
// A DEPTH-entry circular queue accepts up to two decoded instructions per cycle.
// Each cycle it offers the oldest one or two entries to the issue lanes. A pair is
// split when the younger instruction reads the older one's destination register,
// or when both request the same preferred lane.
//
// Optional build macro: ISSUEQ_PERF_EN enables the three 32-bit performance counters.
// When it is undefined, perf_*_o are tied to zero.
//
// Ports:
//   clock_i, reset_n_i             clock; synchronous active-low reset
//   flush_i                        drop every entry (redirect)
//   enq_valid_i/inst/ctrl/pc/pred/pred_tgt
//                                  decode lanes; lane k sits at slice k
//   enq_ready_o                    at least two free entries
//   iss_ready_i                    execute accepts this cycle
//   iss_valid_o + payload          issue lanes; same packing as the enqueue side
//   count_o                        occupied entries
//   perf_dual_o/single_o/dep_o     event counters
//
// ctrl word fields: bit0 REGWRITE, bit1 RS1_ACTIVE, bit2 RS2_ACTIVE,
// bit3 ISSUE_PRI, bit4 ISSUE_SLOT.
// Register numbers come from the RV32 instruction word: rd[11:7], rs1[19:15], rs2[24:20].
module issue_queue #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CTRL_W = 16
) (
    input  logic                      clock_i,
    input  logic                      reset_n_i,
    input  logic                      flush_i,
    input  logic [1:0]                enq_valid_i,
    input  logic [63:0]               enq_inst_i,
    input  logic [2*CTRL_W-1:0]       enq_ctrl_i,
    input  logic [63:0]               enq_pc_i,
    input  logic [1:0]                enq_pred_i,
    input  logic [63:0]               enq_pred_tgt_i,
    output logic                      enq_ready_o,
    input  logic                      iss_ready_i,
    output logic [1:0]                iss_valid_o,
    output logic [63:0]               iss_inst_o,
    output logic [2*CTRL_W-1:0]       iss_ctrl_o,
    output logic [63:0]               iss_pc_o,
    output logic [1:0]                iss_pred_o,
    output logic [63:0]               iss_pred_tgt_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic [31:0]               perf_dual_o,
    output logic [31:0]               perf_single_o,
    output logic [31:0]               perf_dep_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CTRL_REGWRITE   = 0;
    localparam int unsigned CTRL_RS1_ACTIVE = 1;
    localparam int unsigned CTRL_RS2_ACTIVE = 2;
    localparam int unsigned CTRL_ISSUE_PRI  = 3;
    localparam int unsigned CTRL_ISSUE_SLOT = 4;
    localparam logic [PTR_W:0] ENQ_LIMIT = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W:0] CNT_TWO   = (PTR_W+1)'(2);

    logic [31:0]       inst_q [DEPTH];
    logic [CTRL_W-1:0] ctrl_q [DEPTH];
    logic [31:0]       pc_q   [DEPTH];
    logic              pred_q [DEPTH];
    logic [31:0]       tgt_q  [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [PTR_W-1:0] o_idx, y_idx, lane0_idx, lane1_idx;
    logic [4:0]       o_rd, y_rs1, y_rs2;
    logic             o_pri, o_slot, y_pri, y_slot;
    logic             dep, conflict, pair, single, swap, enq_fire, issue_fire;
    logic [1:0]       valid_raw, enq_n, deq_n;

    assign o_idx  = head_q;
    assign y_idx  = head_q + PTR_W'(1);
    assign o_rd   = inst_q[o_idx][11:7];
    assign y_rs1  = inst_q[y_idx][19:15];
    assign y_rs2  = inst_q[y_idx][24:20];
    assign o_pri  = ctrl_q[o_idx][CTRL_ISSUE_PRI];
    assign o_slot = ctrl_q[o_idx][CTRL_ISSUE_SLOT];
    assign y_pri  = ctrl_q[y_idx][CTRL_ISSUE_PRI];
    assign y_slot = ctrl_q[y_idx][CTRL_ISSUE_SLOT];

    // Enqueue readiness uses the pre-cycle count only; same-cycle dequeue earns no credit.
    assign enq_ready_o = (count_q <= ENQ_LIMIT);
    assign enq_fire    = enq_ready_o && !flush_i;
    assign issue_fire  = iss_ready_i && !flush_i;

    always_comb begin
        dep = ctrl_q[o_idx][CTRL_REGWRITE] &&
              ((ctrl_q[y_idx][CTRL_RS1_ACTIVE] && (y_rs1 != 5'd0) && (y_rs1 == o_rd)) ||
               (ctrl_q[y_idx][CTRL_RS2_ACTIVE] && (y_rs2 != 5'd0) && (y_rs2 == o_rd)));
        conflict = o_pri && y_pri && (o_slot == y_slot);
        pair     = (count_q >= CNT_TWO) && !dep && !conflict;
        single   = (count_q != '0) && !pair;
        swap     = (o_pri && o_slot) || (!o_pri && y_pri && !y_slot);

        lane0_idx = o_idx;
        lane1_idx = y_idx;
        valid_raw = 2'b00;
        if (pair) begin
            valid_raw = 2'b11;
            if (swap) begin
                lane0_idx = y_idx;
                lane1_idx = o_idx;
            end
        end else if (single) begin
            if (o_pri && o_slot) begin
                valid_raw = 2'b10;
                lane1_idx = o_idx;
            end else begin
                valid_raw = 2'b01;
            end
        end

        iss_valid_o = flush_i ? 2'b00 : valid_raw;

        enq_n = 2'd0;
        if (enq_fire) begin
            enq_n = {1'b0, enq_valid_i[0]} + {1'b0, enq_valid_i[1]};
        end
        deq_n = 2'd0;
        if (issue_fire) begin
            deq_n = pair ? 2'd2 : (single ? 2'd1 : 2'd0);
        end

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(deq_n);
            tail_d  = tail_q + PTR_W'(enq_n);
            count_d = count_q + (PTR_W+1)'(enq_n) - (PTR_W+1)'(deq_n);
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is live.
    // Lane 1 lands after lane 0 only when lane 0 is also valid.
    always_ff @(posedge clock_i) begin
        if (reset_n_i && enq_fire) begin
            for (int k = 0; k < 2; k++) begin
                if (enq_valid_i[k]) begin
                    inst_q[tail_q + PTR_W'(k == 1 && enq_valid_i[0])] <= enq_inst_i[32*k +: 32];
                    ctrl_q[tail_q + PTR_W'(k == 1 && enq_valid_i[0])] <=
                        enq_ctrl_i[CTRL_W*k +: CTRL_W];
                    pc_q[tail_q + PTR_W'(k == 1 && enq_valid_i[0])]   <= enq_pc_i[32*k +: 32];
                    pred_q[tail_q + PTR_W'(k == 1 && enq_valid_i[0])] <= enq_pred_i[k];
                    tgt_q[tail_q + PTR_W'(k == 1 && enq_valid_i[0])]  <=
                        enq_pred_tgt_i[32*k +: 32];
                end
            end
        end
    end

    assign iss_inst_o     = {inst_q[lane1_idx], inst_q[lane0_idx]};
    assign iss_ctrl_o     = {ctrl_q[lane1_idx], ctrl_q[lane0_idx]};
    assign iss_pc_o       = {pc_q[lane1_idx], pc_q[lane0_idx]};
    assign iss_pred_o     = {pred_q[lane1_idx], pred_q[lane0_idx]};
    assign iss_pred_tgt_o = {tgt_q[lane1_idx], tgt_q[lane0_idx]};
    assign count_o        = count_q;

`ifdef ISSUEQ_PERF_EN
    logic [31:0] perf_dual_q, perf_single_q, perf_dep_q;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            perf_dual_q   <= '0;
            perf_single_q <= '0;
            perf_dep_q    <= '0;
        end else begin
            if (issue_fire && pair) perf_dual_q <= perf_dual_q + 32'd1;
            if (issue_fire && single) perf_single_q <= perf_single_q + 32'd1;
            if ((count_q >= CNT_TWO) && dep && iss_ready_i) perf_dep_q <= perf_dep_q + 32'd1;
        end
    end

    assign perf_dual_o   = perf_dual_q;
    assign perf_single_o = perf_single_q;
    assign perf_dep_o    = perf_dep_q;
`else
    assign perf_dual_o   = '0;
    assign perf_single_o = '0;
    assign perf_dep_o    = '0;
`endif

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed scoreboard bench for issue_queue (DEPTH=8, CTRL_W=16).
// The stimulus pushes the expected issue bundles into a queue.
// A negedge monitor pops one bundle for every cycle the DUT issues with iss_ready high.
// Expected perf values follow ISSUEQ_PERF_EN.
module tb_issue_queue;
    localparam logic [31:0] TGT_XOR = 32'h0000_8000;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic [1:0]  enq_valid;
    logic [63:0] enq_inst;
    logic [31:0] enq_ctrl;
    logic [63:0] enq_pc;
    logic [1:0]  enq_pred;
    logic [63:0] enq_pred_tgt;
    logic        enq_ready;
    logic        iss_ready;
    logic [1:0]  iss_valid;
    logic [63:0] iss_inst;
    logic [31:0] iss_ctrl;
    logic [63:0] iss_pc;
    logic [1:0]  iss_pred;
    logic [63:0] iss_pred_tgt;
    logic [3:0]  count;
    logic [31:0] perf_dual, perf_single, perf_dep;

    issue_queue #(.DEPTH(8), .CTRL_W(16)) dut (
        .clock_i(clk), .reset_n_i(reset_n), .flush_i(flush),
        .enq_valid_i(enq_valid), .enq_inst_i(enq_inst), .enq_ctrl_i(enq_ctrl),
        .enq_pc_i(enq_pc), .enq_pred_i(enq_pred), .enq_pred_tgt_i(enq_pred_tgt),
        .enq_ready_o(enq_ready), .iss_ready_i(iss_ready), .iss_valid_o(iss_valid),
        .iss_inst_o(iss_inst), .iss_ctrl_o(iss_ctrl), .iss_pc_o(iss_pc),
        .iss_pred_o(iss_pred), .iss_pred_tgt_o(iss_pred_tgt), .count_o(count),
        .perf_dual_o(perf_dual), .perf_single_o(perf_single), .perf_dep_o(perf_dep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  v;
        logic [31:0] i0, p0, i1, p1;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   seq    = 0;

`ifdef ISSUEQ_PERF_EN
    localparam int PERF_ON = 1;
`else
    localparam int PERF_ON = 0;
`endif

    function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    function automatic logic [15:0] mk_ctrl(input logic rw, input logic r1, input logic r2,
                                            input logic pri, input logic slot);
        return {11'd0, slot, pri, r2, r1, rw};
    endfunction

    function automatic logic lane_ok(input int k, input logic [31:0] i, input logic [31:0] p);
        return (iss_inst[32*k +: 32] == i) && (iss_pc[32*k +: 32] == p) &&
               (iss_pred[k] == p[2]) && (iss_pred_tgt[32*k +: 32] == (p ^ TGT_XOR));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_iss(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] p0,
                              input logic [31:0] i1, input logic [31:0] p1);
        exp_t e;
        e.v = v; e.i0 = i0; e.p0 = p0; e.i1 = i1; e.p1 = p1;
        sb.push_back(e);
    endtask

    task automatic drive_enq(input logic [1:0] v, input logic [31:0] i0, input logic [15:0] c0,
                             input logic [31:0] i1, input logic [15:0] c1,
                             output logic [31:0] p0, output logic [31:0] p1);
        p0 = 32'h1000 + 32'(seq * 8);
        p1 = p0 + 32'd4;
        seq++;
        enq_valid    = v;
        enq_inst     = {i1, i0};
        enq_ctrl     = {c1, c0};
        enq_pc       = {p1, p0};
        enq_pred     = {p1[2], p0[2]};
        enq_pred_tgt = {p1 ^ TGT_XOR, p0 ^ TGT_XOR};
    endtask

    task automatic enq(input logic [1:0] v, input logic [31:0] i0, input logic [15:0] c0,
                       input logic [31:0] i1, input logic [15:0] c1,
                       output logic [31:0] p0, output logic [31:0] p1);
        drive_enq(v, i0, c0, i1, c1, p0, p1);
        step();
        enq_valid = 2'b00;
    endtask

    // Monitor: every issuing cycle with iss_ready high retires one scoreboard entry.
    always @(negedge clk) begin
        if (reset_n && iss_ready && iss_valid != 2'b00) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got valid=%b inst=%h expected no issue",
                         iss_valid, iss_inst);
            end else begin
                exp_t e;
                logic ok;
                e  = sb.pop_front();
                ok = (iss_valid == e.v);
                if (e.v[0] && !lane_ok(0, e.i0, e.p0)) ok = 1'b0;
                if (e.v[1] && !lane_ok(1, e.i1, e.p1)) ok = 1'b0;
                if (!ok) begin
                    errors++;
                    $display("FAIL issue_bundle: got valid=%b inst=%h pc=%h expected valid=%b inst=%h_%h pc=%h_%h",
                             iss_valid, iss_inst, iss_pc, e.v, e.i1, e.i0, e.p1, e.p0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] plain, pri0, pri1;
        logic [31:0] i0, i1, p0, p1;
        logic [31:0] a0, a1, b0, b1, c0, c1, d0, d1;
        logic [31:0] pa0, pa1, pb0, pb1, pc0, pc1, pd0, pd1;

        plain = mk_ctrl(1, 1, 1, 0, 0);
        pri0  = mk_ctrl(1, 1, 1, 1, 0);
        pri1  = mk_ctrl(1, 1, 1, 1, 1);

        reset_n = 1'b0; flush = 1'b0; iss_ready = 1'b1;
        enq_valid = '0; enq_inst = '0; enq_ctrl = '0; enq_pc = '0;
        enq_pred = '0; enq_pred_tgt = '0;
        step(); step();
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(iss_valid), 0);
        chk("rst_enq_ready", 32'(enq_ready), 1);
        chk("rst_perf_dual", perf_dual, 0);
        chk("rst_perf_single", perf_single, 0);
        chk("rst_perf_dep", perf_dep, 0);
        reset_n = 1'b1;

        // Independent pair issues together in program order.
        i0 = mk_r(7'h00, 5'd2, 5'd1, 5'd5);
        i1 = mk_r(7'h00, 5'd4, 5'd3, 5'd6);
        enq(2'b11, i0, plain, i1, plain, p0, p1);
        expect_iss(2'b11, i0, p0, i1, p1);
        chk("t1_count_full", 32'(count), 2);
        step();
        chk("t1_count_empty", 32'(count), 0);

        // RAW pair: sub x7,x5,x1 reads add's x5, so each issues alone.
        i1 = mk_r(7'h20, 5'd1, 5'd5, 5'd7);
        enq(2'b11, i0, plain, i1, plain, p0, p1);
        expect_iss(2'b01, i0, p0, 0, 0);
        expect_iss(2'b01, i1, p1, 0, 0);
        chk("t2_count2", 32'(count), 2);
        step();
        chk("t2_count1", 32'(count), 1);
        step();
        chk("t2_count0", 32'(count), 0);

        // Older op wants lane 1: swap.
        i0 = mk_r(7'h01, 5'd2, 5'd1, 5'd8);
        i1 = mk_r(7'h00, 5'd4, 5'd3, 5'd9);
        enq(2'b11, i0, pri1, i1, plain, p0, p1);
        expect_iss(2'b11, i1, p1, i0, p0);
        step();

        // Both want lane 0: split into two singles on lane 0.
        i0 = mk_r(7'h01, 5'd2, 5'd1, 5'd10);
        i1 = mk_r(7'h01, 5'd4, 5'd3, 5'd11);
        enq(2'b11, i0, pri0, i1, pri0, p0, p1);
        expect_iss(2'b01, i0, p0, 0, 0);
        expect_iss(2'b01, i1, p1, 0, 0);
        step(); step();

        // Lone instruction steered to lane 1.
        i0 = mk_r(7'h00, 5'd2, 5'd1, 5'd12);
        enq(2'b01, i0, pri1, 0, plain, p0, p1);
        expect_iss(2'b10, 0, 0, i0, p0);
        step();

        // Younger op wants lane 0 while older has no preference: swap.
        i0 = mk_r(7'h00, 5'd2, 5'd1, 5'd13);
        i1 = mk_r(7'h00, 5'd4, 5'd3, 5'd14);
        enq(2'b11, i0, plain, i1, pri0, p0, p1);
        expect_iss(2'b11, i1, p1, i0, p0);
        step();
        chk("t3_count0", 32'(count), 0);

        // Fill all eight entries while stalled, then drain across the pointer wrap.
        iss_ready = 1'b0;
        a0 = mk_r(0, 5'd2, 5'd1, 5'd10); a1 = mk_r(0, 5'd2, 5'd1, 5'd11);
        b0 = mk_r(0, 5'd2, 5'd1, 5'd12); b1 = mk_r(0, 5'd1, 5'd12, 5'd13);
        c0 = mk_r(0, 5'd2, 5'd1, 5'd14); c1 = mk_r(0, 5'd2, 5'd1, 5'd15);
        d0 = mk_r(0, 5'd2, 5'd1, 5'd16); d1 = mk_r(0, 5'd2, 5'd1, 5'd17);
        enq(2'b11, a0, plain, a1, plain, pa0, pa1);
        chk("t4_ready_at2", 32'(enq_ready), 1);
        enq(2'b11, b0, plain, b1, plain, pb0, pb1);
        enq(2'b11, c0, plain, c1, plain, pc0, pc1);
        chk("t4_ready_at6", 32'(enq_ready), 1);
        enq(2'b11, d0, plain, d1, plain, pd0, pd1);
        chk("t4_count_full", 32'(count), 8);
        chk("t4_ready_full", 32'(enq_ready), 0);
        chk("t4_stall_valid", 32'(iss_valid), 32'h3);
        enq(2'b11, mk_r(0, 5'd2, 5'd1, 5'd20), plain, mk_r(0, 5'd2, 5'd1, 5'd21), plain, p0, p1);
        chk("t4_full_ignored", 32'(count), 8);
        expect_iss(2'b11, a0, pa0, a1, pa1);
        expect_iss(2'b01, b0, pb0, 0, 0);
        expect_iss(2'b11, b1, pb1, c0, pc0);
        expect_iss(2'b11, c1, pc1, d0, pd0);
        expect_iss(2'b01, d1, pd1, 0, 0);
        iss_ready = 1'b1;
        step(); step(); step(); step(); step();
        chk("t4_count0", 32'(count), 0);

        // Flush at count 5 with a same-cycle enqueue that must be dropped.
        iss_ready = 1'b0;
        enq(2'b11, mk_r(0, 5'd2, 5'd1, 5'd18), plain, mk_r(0, 5'd2, 5'd1, 5'd19), plain, p0, p1);
        enq(2'b11, mk_r(0, 5'd2, 5'd1, 5'd20), plain, mk_r(0, 5'd2, 5'd1, 5'd21), plain, p0, p1);
        enq(2'b01, mk_r(0, 5'd2, 5'd1, 5'd22), plain, 0, plain, p0, p1);
        chk("t5_count5", 32'(count), 5);
        drive_enq(2'b11, mk_r(0, 5'd2, 5'd1, 5'd23), plain, mk_r(0, 5'd2, 5'd1, 5'd24), plain,
                  p0, p1);
        flush = 1'b1; iss_ready = 1'b1;
        #1;
        chk("t5_flush_valid", 32'(iss_valid), 0);
        step();
        enq_valid = 2'b00; flush = 1'b0;
        chk("t5_count_after", 32'(count), 0);
        chk("t5_valid_after", 32'(iss_valid), 0);

        // Enqueue and dequeue of a pair in the same cycle.
        i0 = mk_r(0, 5'd2, 5'd1, 5'd25); i1 = mk_r(0, 5'd2, 5'd1, 5'd26);
        enq(2'b11, i0, plain, i1, plain, p0, p1);
        expect_iss(2'b11, i0, p0, i1, p1);
        i0 = mk_r(0, 5'd2, 5'd1, 5'd27); i1 = mk_r(0, 5'd2, 5'd1, 5'd28);
        enq(2'b11, i0, plain, i1, plain, p0, p1);
        expect_iss(2'b11, i0, p0, i1, p1);
        chk("t5_count_overlap", 32'(count), 2);
        step();
        chk("t5_count0", 32'(count), 0);

        chk("perf_dual", perf_dual, PERF_ON ? 32'd8 : 32'd0);
        chk("perf_single", perf_single, PERF_ON ? 32'd7 : 32'd0);
        chk("perf_dep", perf_dep, PERF_ON ? 32'd2 : 32'd0);

        // Reset mid-stream discards contents and clears counters.
        iss_ready = 1'b0;
        enq(2'b11, mk_r(0, 5'd2, 5'd1, 5'd29), plain, mk_r(0, 5'd2, 5'd1, 5'd30), plain, p0, p1);
        enq(2'b01, mk_r(0, 5'd2, 5'd1, 5'd31), plain, 0, plain, p0, p1);
        chk("t6_count3", 32'(count), 3);
        reset_n = 1'b0;
        step();
        chk("t6_count", 32'(count), 0);
        chk("t6_valid", 32'(iss_valid), 0);
        chk("t6_enq_ready", 32'(enq_ready), 1);
        chk("t6_perf_dual", perf_dual, 0);
        chk("t6_perf_single", perf_single, 0);
        chk("t6_perf_dep", perf_dep, 0);
        reset_n = 1'b1; iss_ready = 1'b1;
        i0 = mk_r(0, 5'd2, 5'd1, 5'd3); i1 = mk_r(0, 5'd2, 5'd1, 5'd4);
        enq(2'b11, i0, plain, i1, plain, p0, p1);
        expect_iss(2'b11, i0, p0, i1, p1);
        step();
        chk("t6_count0", 32'(count), 0);
        step();
        chk("sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
